// File: rtl/uart_rx_if.sv
// Serial receive bundle: line input from the pin side, byte/strobe outputs to the consumer.
// The receiver attaches through the slave modport; the line driver/consumer uses master.
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);
   logic                 rx;
   logic [DATA_BITS-1:0] dout;
   logic                 done;
   logic                 err;
   logic                 busy;

   modport master (output rx, input dout, done, err, busy);
   modport slave  (input rx, output dout, done, err, busy);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, single mid-bit sample per bit, LSB first,
// one-cycle done/err strobes, and a BREAK state that swallows a held-low line.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic       clk_i,
   input  logic       rst_i,
   uart_rx_if.slave   bus
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CW-1:0] HALF_TC  = CW'(CLKS_PER_BIT/2 - 1);
   localparam logic [CW-1:0] FULL_TC  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_e;

   logic                 sync1_q, sync2_q;
   logic                 rx_s;
   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] dout_q, dout_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;

   // Synchronizer idles high so reset never looks like a start edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= bus.rx;
         sync2_q <= sync1_q;
      end
   end

   assign rx_s = sync2_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d = S_START;
               cnt_d   = '0;
            end
         end

         // Half a bit in, so every later sample lands mid-bit.
         S_START: begin
            if (cnt_q == HALF_TC) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s ? S_IDLE : S_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_DATA: begin
            if (cnt_q == FULL_TC) begin
               cnt_d          = '0;
               shreg_d[idx_q] = rx_s;
               if (idx_q == LAST_BIT) begin
                  state_d = S_STOP;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         S_STOP: begin
            if (cnt_q == FULL_TC) begin
               cnt_d = '0;
               if (rx_s) begin
                  dout_d  = shreg_q;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  err_d   = 1'b1;
                  state_d = S_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end

         // A line stuck low must rise before another start edge is honoured.
         S_BREAK: begin
            if (rx_s) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.dout = dout_q;
   assign bus.done = done_q;
   assign bus.err  = err_q;
   assign bus.busy = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

endmodule
